// File: rtl/counter_mod.sv
// counter_mod: parametrised modulo-N up/down counter with clear, load and wrap pulse.
//
// Parameters
//   WIDTH   counter register width, 1..32
//   MODULO  count range 0..MODULO-1, 2..2**WIDTH
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        count enable (one step per enabled cycle)
//   up        direction: 1 = increment, 0 = decrement
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load (clamped to MODULO-1)
//   load_val  value to load
//   count     registered count
//   wrap      registered one-cycle pulse on modulo wrap
//   at_max    count == MODULO-1
//   at_zero   count == 0
// Build option
//   COUNTER_MOD_SATURATE_EN  saturate at the ends instead of wrapping; wrap stays 0.
module counter_mod #(
  parameter int     WIDTH  = 4,
  parameter longint MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_mod: WIDTH must be in 1..32");
    end
    if (MODULO < 2 || MODULO > (64'sd1 << WIDTH)) begin : g_bad_modulo
      $error("counter_mod: MODULO must be in 2..2**WIDTH");
    end
  endgenerate

  // MODULO itself may equal 2**WIDTH, so it only fits in WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;

  assign inc = {1'b0, count} + 1'b1;
  assign dec = {1'b0, count} - 1'b1;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        // Reaching MODULO means we stepped past MODULO-1.
        if (inc >= MOD_EXT) begin
`ifdef COUNTER_MOD_SATURATE_EN
          count_nxt = MAX_V;
`else
          count_nxt = '0;
          wrap_nxt  = 1'b1;
`endif
        end else begin
          count_nxt = inc[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extended bit means we decremented from 0.
        if (dec[WIDTH]) begin
`ifdef COUNTER_MOD_SATURATE_EN
          count_nxt = '0;
`else
          count_nxt = MAX_V;
          wrap_nxt  = 1'b1;
`endif
        end else begin
          count_nxt = dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         wrap, at_max, at_zero;

  counter_mod #(.WIDTH(W), .MODULO(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .at_max(at_max),
    .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  typedef struct { int cnt; int wr; } exp_t;
  exp_t q[$];
  int   m = 0;          // reference count
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: apply the priority rules with plain integer arithmetic.
  task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
    exp_t x;
    @(negedge clk);
    rst = 1'b1; en = e; up = u; clr = c; load = l; load_val = W'(lv);
    x.wr = 0;
    if (c) m = 0;
    else if (l) m = (lv >= MOD) ? MOD - 1 : lv;
    else if (e) begin
      if (u && m == MOD - 1) begin
`ifdef COUNTER_MOD_SATURATE_EN
        m = MOD - 1;
`else
        m = 0; x.wr = 1;
`endif
      end else if (!u && m == 0) begin
`ifdef COUNTER_MOD_SATURATE_EN
        m = 0;
`else
        m = MOD - 1; x.wr = 1;
`endif
      end else m = u ? m + 1 : m - 1;
    end
    x.cnt = m;
    q.push_back(x);
  endtask

  // Monitor: every rising edge the DUT presents a new count; compare to scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count",   int'(count),   e.cnt);
        chk("wrap",    int'(wrap),    e.wr);
        chk("at_max",  int'(at_max),  int'(e.cnt == MOD - 1));
        chk("at_zero", int'(at_zero), int'(e.cnt == 0));
      end
    end
  end

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_count",   int'(count),   0);
    chk("rst_wrap",    int'(wrap),    0);
    chk("rst_at_zero", int'(at_zero), 1);
    chk("rst_at_max",  int'(at_max),  0);
    m = 0;
    // Inputs that would count are ignored while held in reset.
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
    repeat (2) @(negedge clk);
    chk("rst_hold_count", int'(count), 0);
  endtask

  initial begin
    int budget;
    // Power-on reset values before any clock edge.
    #2;
    chk("por_count",   int'(count),   0);
    chk("por_at_zero", int'(at_zero), 1);
    chk("por_at_max",  int'(at_max),  0);
    chk("por_wrap",    int'(wrap),    0);

    // Reset mid-count at 7, then release with en=1,up=1 -> 1.
    step(0, 0, 0, 1, 7);
    async_reset_check();
    step(1, 1, 0, 0, 0);

    // Up wrap over 12 cycles from 0.
    step(0, 0, 1, 0, 0);
    repeat (12) step(1, 1, 0, 0, 0);

    // Down wrap from 1.
    step(0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0);

    // Priority and clamping.
    step(0, 0, 0, 1, 5);
    step(1, 1, 1, 1, 3);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 15);
    step(0, 0, 0, 1, 10);

    // Direction toggle, then hold.
    step(0, 0, 0, 1, 4);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);

    // End behaviour near the limits (wraps by default, saturates with the option).
    step(0, 0, 0, 1, 8);
    repeat (4) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0);

    // Randomised traffic with an occasional mid-count reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 150 || i == 300) begin
        async_reset_check();
      end
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)));
    end

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_timeout", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo-N up/down counter. It is the general-purpose successor to the fixed 4-bit free-running counter and adds configurable width and modulus, direction control, count enable, synchronous clear, parallel load and a wrap pulse. It sits beside the fabric clock as a building block for dividers, timers and LED/sequence demos in the toolchain's example designs.

## Interface
- WIDTH, 4, counter register width in bits; legal range 1..32.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH.
- Illegal WIDTH/MODULO combinations must cause an elaboration error via a `$error` in a generate check.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle registered pulse on modulo wrap.
- at_max  output  1  count == MODULO-1, decoded from the count register.
- at_zero  output  1  count == 0, decoded from the count register.

## Operation
- Priority at each rising edge is clr > load > en > hold.
- clr sets count to 0 and wrap to 0, regardless of en and load.
- load sets count to load_val. If load_val >= MODULO, count is clamped to MODULO-1. wrap is 0.
- en with up=1: count==MODULO-1 goes to 0 and sets wrap=1; otherwise count+1 and wrap=0.
- en with up=0: count==0 goes to MODULO-1 and sets wrap=1; otherwise count-1 and wrap=0.
- en=0 with no clr/load: count holds and wrap=0.
- Arithmetic is done in WIDTH+1 bits internally. count never takes a value >= MODULO.
- Direction may change on any cycle. The new direction applies to that cycle's step with no extra latency.
- at_max and at_zero are both 1 only when MODULO==1, which is illegal, so they are never both 1.

## Timing
- Reset: rst low forces count=0 and wrap=0 immediately, with no clock needed. Consequently at_zero=1 and at_max=0.
- rst is released asynchronously. The first step occurs on the first rising clk edge with rst=1 and en=1.
- Reset asserted mid-count overrides everything. A pending load or clr is discarded.
- Latency: input to count change is 1 clock. wrap is asserted in the same cycle that count shows the wrapped value, for exactly one cycle per wrap.
- With en held high at up=1, wrap pulses every MODULO cycles.
- at_max and at_zero are combinational from the count flops only, with no input-to-output combinational path.

## Configuration
- COUNTER_MOD_SATURATE_EN defined: the counter saturates instead of wrapping.
  - Increment at MODULO-1 holds MODULO-1.
  - Decrement at 0 holds 0.
  - wrap is tied to 0.
  - clr, load and clamping are unchanged.
- COUNTER_MOD_SATURATE_EN undefined: modulo wrap behaviour as described above (default).

## Test plan
- Reset: hold rst=0 mid-count at 7, with no clk edges → count=0, wrap=0 and at_zero=1 immediately. Release rst with en=1, up=1 → count=1 after the first edge.
- Up wrap (WIDTH=4, MODULO=10): en=1, up=1 from 0 for 12 cycles → count 1..9,0,1,2. wrap=1 only in the cycle count=0 after 9. at_max=1 while count=9.
- Down wrap (WIDTH=4, MODULO=10): load 1, then en=1, up=0 for 3 cycles → count 0,9,8. wrap=1 exactly at 9.
- Priority: at count=5 assert clr=1, load=1 with load_val=3, en=1 → count=0. Next cycle load=1 only → count=3. Then load_val=15 → count=9 (clamped).
- Direction toggle: from 4, alternate up=1/0 each cycle with en=1 → count 5,4,5,4. en=0 for 2 cycles → count holds at 4 and wrap stays 0.
- With COUNTER_MOD_SATURATE_EN (MODULO=10): count up from 8 for 4 cycles → 9,9,9,9. Count down from 1 for 3 cycles → 0,0,0. wrap never asserts.
